// File: rtl/dds_note_scheduler.sv
// dds_note_scheduler: time-shares one note-to-phase-increment converter among
// VOICES synth voices. Note writes mark a voice pending; pending voices are
// launched round-robin, and each result is strobed out and stored for readback.
module dds_note_scheduler #(
    parameter int unsigned VOICES   = 8,
    parameter int unsigned VW       = 3,
    parameter int unsigned CONV_LAT = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          WR_EN,
    input  logic [VW-1:0] WR_VOICE,
    input  logic [6:0]    WR_NOTE,
    output logic [6:0]    CONV_NOTE,
    input  logic [31:0]   CONV_ADDER,
    output logic          UPD_VALID,
    output logic [VW-1:0] UPD_VOICE,
    output logic [31:0]   UPD_ADDER,
    input  logic [VW-1:0] RD_VOICE,
    output logic [31:0]   RD_ADDER,
    output logic          BUSY
);

    localparam int unsigned NW = 7;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [VOICES-1:0] pending, pending_nxt;
    logic [VW-1:0]     ptr, ptr_nxt;
    logic [VW-1:0]     cur, cur_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              abort, abort_nxt;
    logic [NW-1:0]     conv_note, conv_note_nxt;
    logic              upd_valid, upd_valid_nxt;
    logic [VW-1:0]     upd_voice, upd_voice_nxt;
    logic [AW-1:0]     upd_adder, upd_adder_nxt;
    logic              tbl_we;

    logic [NW-1:0]     note_tbl  [VOICES];
    logic [AW-1:0]     adder_tbl [VOICES];

    logic [VW-1:0]     sel;
    logic [VW-1:0]     sel_idx;
    logic              sel_found;

    // Round-robin pick: first pending voice at or above ptr, wrapping.
    always_comb begin
        sel       = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < int'(VOICES); i++) begin
            sel_idx = ptr + VW'(i);
            if (!sel_found && pending[sel_idx]) begin
                sel       = sel_idx;
                sel_found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic for the launch/wait sequencer.
    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        ptr_nxt       = ptr;
        cur_nxt       = cur;
        cnt_nxt       = cnt;
        abort_nxt     = abort;
        conv_note_nxt = conv_note;
        upd_valid_nxt = 1'b0;
        upd_voice_nxt = upd_voice;
        upd_adder_nxt = upd_adder;
        tbl_we        = 1'b0;

        case (state)
            S_IDLE: begin
                if (sel_found) begin
                    conv_note_nxt     = note_tbl[sel];
                    pending_nxt[sel]  = 1'b0;
                    cur_nxt           = sel;
                    cnt_nxt           = CW'(CONV_LAT);
                    ptr_nxt           = sel + VW'(1);
                    state_nxt         = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                    // A newer note for the in-flight voice makes this result stale.
                    if (WR_EN && (WR_VOICE == cur)) begin
                        abort_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = S_IDLE;
                    abort_nxt = 1'b0;
                    if (!abort) begin
                        upd_valid_nxt = 1'b1;
                        upd_voice_nxt = cur;
                        upd_adder_nxt = CONV_ADDER;
                        tbl_we        = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A write re-arms the voice even if it is being launched this cycle.
        if (WR_EN) begin
            pending_nxt[WR_VOICE] = 1'b1;
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            pending   <= '0;
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
            abort     <= 1'b0;
            conv_note <= '0;
            upd_valid <= 1'b0;
            upd_voice <= '0;
            upd_adder <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            ptr       <= ptr_nxt;
            cur       <= cur_nxt;
            cnt       <= cnt_nxt;
            abort     <= abort_nxt;
            conv_note <= conv_note_nxt;
            upd_valid <= upd_valid_nxt;
            upd_voice <= upd_voice_nxt;
            upd_adder <= upd_adder_nxt;
        end
    end

    // Per-voice note and adder tables.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(VOICES); i++) begin
                note_tbl[i]  <= '0;
                adder_tbl[i] <= '0;
            end
        end else begin
            if (WR_EN) begin
                note_tbl[WR_VOICE] <= WR_NOTE;
            end
            if (tbl_we) begin
                adder_tbl[cur] <= CONV_ADDER;
            end
        end
    end

    assign CONV_NOTE = conv_note;
    assign UPD_VALID = upd_valid;
    assign UPD_VOICE = upd_voice;
    assign UPD_ADDER = upd_adder;
    assign RD_ADDER  = adder_tbl[RD_VOICE];
    assign BUSY      = (state != S_IDLE) || (pending != '0);

endmodule
